// File: rtl/axi_frame_pkg.sv
// Constants shared by the AXI4 frame writer and frame reader: FSM encoding,
// fixed AXI read/write attributes and frame geometry.
package axi_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        NEXT = 2'd3
    } frame_state_e;

    localparam logic [7:0] BURST_LEN   = 8'd63;
    localparam logic [2:0] SIZE_8B     = 3'b011;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [3:0] CACHE_BUF   = 4'b0011;
    localparam logic [2:0] PROT_0      = 3'b000;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    localparam int unsigned FRAME_BYTES = 153600;
    localparam int unsigned BURST_BYTES = 512;

endpackage

// File: rtl/axi4_frame_reader.sv
// AXI4 read master that fetches one frame from the idle double buffer as a
// sequence of single-outstanding INCR bursts and streams beats to the HDMI FIFO.
module axi4_frame_reader #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned BURST_BEATS    = 64,
    parameter int unsigned FRAME_BYTES    = 153600,
    parameter logic [AXI_ADDR_WIDTH-1:0] BUF0_BASE = 32'h1000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] BUF1_BASE = 32'h1008_0000
) (
    input  logic                        clk_100Mhz,
    input  logic                        rst_n,
    input  logic                        frame_start,
    input  logic                        rd_buf_select,
    input  logic                        space_ok,
    output logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    output logic [7:0]                  ARLEN,
    output logic [2:0]                  ARSIZE,
    output logic [1:0]                  ARBURST,
    output logic [3:0]                  ARCACHE,
    output logic [2:0]                  ARPROT,
    input  logic [AXI_DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]                  RRESP,
    input  logic                        RLAST,
    input  logic                        RVALID,
    output logic                        RREADY,
    output logic [AXI_DATA_WIDTH-1:0]   out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_eof,
    output logic                        reader_done,
    output logic                        frame_busy,
    output logic                        resp_err,
    output logic [1:0]                  state
);
    import axi_frame_pkg::*;

    localparam int unsigned BEAT_W = $clog2(BURST_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_SPAN =
        AXI_ADDR_WIDTH'(BURST_BEATS * (AXI_DATA_WIDTH / 8));
    localparam logic [AXI_ADDR_WIDTH-1:0] LAST_OFFSET =
        AXI_ADDR_WIDTH'(FRAME_BYTES) - BURST_SPAN;

    frame_state_e                 state_r;
    frame_state_e                 state_nx_s;
    logic [AXI_ADDR_WIDTH-1:0]    base_r;
    logic [AXI_ADDR_WIDTH-1:0]    offset_r;
    logic [AXI_ADDR_WIDTH-1:0]    araddr_r;
    logic                         arvalid_r;
    logic                         frame_busy_r;
    logic                         restart_pend_r;
    logic                         pend_sel_r;
    logic                         reader_done_r;
    logic                         resp_err_r;
    logic [BEAT_W-1:0]            beat_cnt_r;

    logic                         in_data_s;
    logic                         beat_fire_s;
    logic                         last_beat_s;
    logic                         last_burst_s;
    logic                         ar_fire_s;
    logic                         beat_bad_s;
    logic                         issue_s;
    logic                         restart_s;
    logic                         restart_sel_s;
    logic                         frame_end_s;
    logic                         advance_s;

    assign in_data_s    = (state_r == DATA);
    assign beat_fire_s  = RVALID && RREADY;
    assign last_beat_s  = beat_fire_s && (beat_cnt_r == LAST_BEAT);
    assign last_burst_s = (offset_r == LAST_OFFSET);
    assign ar_fire_s    = arvalid_r && ARREADY;
    // RLAST must coincide exactly with the counted last beat.
    assign beat_bad_s   = (RRESP != RESP_OKAY) || (RLAST != (beat_cnt_r == LAST_BEAT));

    // FSM state register
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode and one-cycle control strobes for the datapath
    always_comb begin
        state_nx_s    = state_r;
        issue_s       = 1'b0;
        restart_s     = 1'b0;
        restart_sel_s = rd_buf_select;
        frame_end_s   = 1'b0;
        advance_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (frame_start) begin
                    restart_s = 1'b1;
                end else if (frame_busy_r && space_ok) begin
                    issue_s    = 1'b1;
                    state_nx_s = ADDR;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ADDR: begin
                if (ar_fire_s) begin
                    state_nx_s = DATA;
                end else begin
                    state_nx_s = ADDR;
                end
            end
            DATA: begin
                if (last_beat_s) begin
                    state_nx_s = NEXT;
                end else begin
                    state_nx_s = DATA;
                end
            end
            NEXT: begin
                state_nx_s = IDLE;
                // A fresh vsync in this cycle beats both a stale pending restart and completion.
                if (frame_start || restart_pend_r) begin
                    restart_s     = 1'b1;
                    restart_sel_s = frame_start ? rd_buf_select : pend_sel_r;
                end else if (last_burst_s) begin
                    frame_end_s = 1'b1;
                end else begin
                    advance_s = 1'b1;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Frame bookkeeping: buffer base, burst offset, busy flag and deferred restart
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            base_r         <= '0;
            offset_r       <= '0;
            frame_busy_r   <= 1'b0;
            restart_pend_r <= 1'b0;
            pend_sel_r     <= 1'b0;
            reader_done_r  <= 1'b0;
        end else begin
            reader_done_r <= frame_end_s;
            if (restart_s) begin
                base_r         <= restart_sel_s ? BUF1_BASE : BUF0_BASE;
                offset_r       <= '0;
                frame_busy_r   <= 1'b1;
                restart_pend_r <= 1'b0;
            end else if (frame_end_s) begin
                frame_busy_r <= 1'b0;
                offset_r     <= '0;
            end else if (advance_s) begin
                offset_r <= offset_r + BURST_SPAN;
            end else if (frame_start && frame_busy_r) begin
                restart_pend_r <= 1'b1;
                pend_sel_r     <= rd_buf_select;
            end else begin
                offset_r <= offset_r;
            end
        end
    end

    // Read-address channel: address captured at issue, held until accepted
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            araddr_r  <= '0;
            arvalid_r <= 1'b0;
        end else if (issue_s) begin
            araddr_r  <= base_r + offset_r;
            arvalid_r <= 1'b1;
        end else if (ar_fire_s) begin
            arvalid_r <= 1'b0;
        end else begin
            arvalid_r <= arvalid_r;
        end
    end

    // Read-data channel: beat counter and sticky response/framing error
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= '0;
            resp_err_r <= 1'b0;
        end else if (beat_fire_s) begin
            beat_cnt_r <= beat_cnt_r + 1'b1;
            resp_err_r <= resp_err_r | beat_bad_s;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign ARADDR      = araddr_r;
    assign ARVALID     = arvalid_r;
    assign ARLEN       = 8'(BURST_BEATS - 1);
    assign ARSIZE      = SIZE_8B;
    assign ARBURST     = BURST_INCR;
    assign ARCACHE     = CACHE_BUF;
    assign ARPROT      = PROT_0;
    assign RREADY      = in_data_s && out_ready;
    assign out_data    = RDATA;
    assign out_valid   = RVALID && in_data_s;
    assign out_eof     = out_valid && (beat_cnt_r == LAST_BEAT) && last_burst_s;
    assign reader_done = reader_done_r;
    assign frame_busy  = frame_busy_r;
    assign resp_err    = resp_err_r;
    assign state       = state_r;

endmodule

// File: tb/tb_axi4_frame_reader.sv
// Directed bench for axi4_frame_reader: a reactive AXI slave model driven on the
// falling edge, table-driven whole-frame runs, and hand-written corner sequences.
module tb_axi4_frame_reader;

    localparam logic [31:0] BUF0 = 32'h1000_0000;
    localparam logic [31:0] BUF1 = 32'h1008_0000;
    localparam logic [31:0] LAST_OFF = 32'd153088;

    logic        clk_100Mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        rd_buf_select = 1'b0;
    logic        space_ok = 1'b0;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPROT;
    logic [63:0] RDATA = 64'd0;
    logic [1:0]  RRESP = 2'b00;
    logic        RLAST = 1'b0;
    logic        RVALID = 1'b0;
    logic        RREADY;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_eof;
    logic        reader_done;
    logic        frame_busy;
    logic        resp_err;
    logic [1:0]  state;

    always #5 clk_100Mhz = ~clk_100Mhz;

    axi4_frame_reader dut (
        .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .frame_start(frame_start),
        .rd_buf_select(rd_buf_select), .space_ok(space_ok),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_eof(out_eof), .reader_done(reader_done), .frame_busy(frame_busy),
        .resp_err(resp_err), .state(state)
    );

    typedef struct {
        logic        sel;
        int          ar_delay;
        int          ordy_mode;
        logic [31:0] first_ar;
        logic [31:0] last_ar;
    } vec_t;
    vec_t vecs[2];

    int n_pass = 0;
    int n_total = 0;

    // stimulus intent applied on the next falling edge
    logic rst_n_n = 1'b0, fs_n = 1'b0, sel_n = 1'b0, space_n = 1'b0;
    int   ar_delay = 0, ordy_mode = 0, cyc = 0;

    // slave / scoreboard state
    logic [31:0] exp_base, exp_off, cur_addr, arv_addr, first_ar, last_ar, snap_addr;
    logic        burst_active, arv_pending, err_snap;
    int cur_beat, cur_idx, ar_wait, n_ar, n_beats, n_eof, eof_at, n_done, proto_err;
    int resp_inj, last_inj, snap_idx, err_snap_idx;
    logic a1, a2;
    int av_seen;
    logic reached;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic reset_model();
        burst_active = 1'b0; arv_pending = 1'b0; arv_addr = 32'd0;
        cur_beat = 0; cur_idx = -1; cur_addr = 32'd0; ar_wait = 0;
        n_ar = 0; n_beats = 0; n_eof = 0; eof_at = 0; n_done = 0; proto_err = 0;
        exp_off = 32'd0; first_ar = 32'd0; last_ar = 32'd0; snap_addr = 32'd0;
        resp_inj = -1; last_inj = -1; snap_idx = -1; err_snap_idx = -1; err_snap = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, then observe what the next rising edge will see.
    task automatic tick();
        logic exp_eof;
        @(negedge clk_100Mhz);
        rst_n = rst_n_n;
        frame_start = fs_n;
        rd_buf_select = sel_n;
        space_ok = space_n;
        out_ready = (ordy_mode == 1) ? ((cyc % 3) != 2) : 1'b1;
        ARREADY = ARVALID && (ar_wait >= ar_delay);
        if (burst_active) begin
            RVALID = 1'b1;
            RDATA  = {cur_addr, 32'(cur_beat)};
            RLAST  = (cur_beat == 63) || (cur_idx == last_inj && cur_beat == 40);
            RRESP  = (cur_idx == resp_inj && cur_beat == 7) ? 2'b10 : 2'b00;
        end else begin
            RVALID = 1'b0; RDATA = 64'd0; RLAST = 1'b0; RRESP = 2'b00;
        end
        #1;
        cyc++;
        if (reader_done) n_done++;
        if (RVALID) begin
            if (RREADY !== out_ready) proto_err++;
            if (RREADY) begin
                exp_eof = (cur_beat == 63) && (cur_addr == exp_base + LAST_OFF);
                if (out_valid !== 1'b1 || out_data !== {cur_addr, 32'(cur_beat)}) proto_err++;
                if (out_eof !== exp_eof) proto_err++;
                if (out_eof) begin
                    n_eof++;
                    eof_at = n_beats + 1;
                end
                n_beats++;
                cur_beat++;
                if (cur_beat == 64) burst_active = 1'b0;
            end
        end
        if (ARVALID) begin
            if (arv_pending && ARADDR !== arv_addr) proto_err++;
            if (ARREADY) begin
                if (burst_active) proto_err++;
                if (ARADDR !== exp_base + exp_off) proto_err++;
                if (n_ar == 0) first_ar = ARADDR;
                if (n_ar == snap_idx) snap_addr = ARADDR;
                if (n_ar == err_snap_idx) err_snap = resp_err;
                last_ar = ARADDR;
                cur_addr = ARADDR; cur_idx = n_ar; cur_beat = 0; burst_active = 1'b1;
                n_ar++;
                exp_off = exp_off + 32'd512;
                arv_pending = 1'b0; ar_wait = 0;
            end else begin
                arv_pending = 1'b1; arv_addr = ARADDR; ar_wait++;
            end
        end else begin
            if (arv_pending) proto_err++;
            arv_pending = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 0, 0, 32'h1000_0000, 32'h1002_5600};
        vecs[1] = '{1'b1, 5, 1, 32'h1008_0000, 32'h100A_5600};
        reset_model();
        exp_base = BUF0;
        repeat (3) tick();

        chk("rst_araddr", 64'(ARADDR), 64'h0);
        chk("rst_arvalid", 64'(ARVALID), 64'h0);
        chk("rst_rready", 64'(RREADY), 64'h0);
        chk("rst_busy", 64'(frame_busy), 64'h0);
        chk("rst_done", 64'(reader_done), 64'h0);
        chk("rst_err", 64'(resp_err), 64'h0);
        chk("rst_state", 64'(state), 64'h0);
        chk("ar_consts", {44'd0, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT}, {44'd0, 8'd63, 3'b011, 2'b01, 4'b0011, 3'b000});

        rst_n_n = 1'b1;
        tick();

        // Whole-frame runs: nominal, then ARREADY delay plus out_ready backpressure.
        for (int v = 0; v < 2; v++) begin
            reset_model();
            exp_base = vecs[v].sel ? BUF1 : BUF0;
            ar_delay = vecs[v].ar_delay;
            ordy_mode = vecs[v].ordy_mode;
            fs_n = 1'b1; sel_n = vecs[v].sel; space_n = 1'b1;
            tick();
            fs_n = 1'b0;
            tick(); a1 = ARVALID;
            tick(); a2 = ARVALID;
            for (int i = 0; i < 45000 && n_done == 0; i++) tick();
            repeat (5) tick();
            chk($sformatf("v%0d_fs_to_arvalid", v), {62'd0, a1, a2}, 64'd1);
            chk($sformatf("v%0d_ar_count", v), 64'(n_ar), 64'd300);
            chk($sformatf("v%0d_first_ar", v), 64'(first_ar), 64'(vecs[v].first_ar));
            chk($sformatf("v%0d_last_ar", v), 64'(last_ar), 64'(vecs[v].last_ar));
            chk($sformatf("v%0d_beats", v), 64'(n_beats), 64'd19200);
            chk($sformatf("v%0d_eof_count", v), 64'(n_eof), 64'd1);
            chk($sformatf("v%0d_eof_at", v), 64'(eof_at), 64'd19200);
            chk($sformatf("v%0d_done_pulses", v), 64'(n_done), 64'd1);
            chk($sformatf("v%0d_resp_err", v), 64'(resp_err), 64'd0);
            chk($sformatf("v%0d_busy_end", v), 64'(frame_busy), 64'd0);
            chk($sformatf("v%0d_protocol", v), 64'(proto_err), 64'd0);
        end

        // space_ok held low, then a restart mid-burst into buffer 1 with injected errors.
        reset_model();
        exp_base = BUF0; ar_delay = 0; ordy_mode = 0;
        snap_idx = 11; err_snap_idx = 13; resp_inj = 13; last_inj = 16;
        fs_n = 1'b1; sel_n = 1'b0; space_n = 1'b0;
        tick();
        fs_n = 1'b0;
        av_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ARVALID) av_seen++;
        end
        chk("nospace_arvalid", 64'(av_seen), 64'd0);
        chk("nospace_busy", 64'(frame_busy), 64'd1);
        space_n = 1'b1;
        tick(); a1 = ARVALID;
        tick(); a2 = ARVALID;
        chk("space_ok_latency", {62'd0, a1, a2}, 64'd1);
        for (int i = 0; i < 5000 && !(n_ar == 11 && cur_beat == 20); i++) tick();
        reached = (n_ar == 11 && cur_beat == 20);
        chk("reach_burst10_beat20", 64'(reached), 64'd1);
        fs_n = 1'b1; sel_n = 1'b1;
        tick();
        fs_n = 1'b0;
        exp_base = BUF1; exp_off = 32'd0;
        for (int i = 0; i < 45000 && n_done == 0; i++) tick();
        repeat (5) tick();
        chk("restart_ar_addr", 64'(snap_addr), 64'(BUF1));
        chk("restart_ar_count", 64'(n_ar), 64'd311);
        chk("restart_beats", 64'(n_beats), 64'(311 * 64));
        chk("restart_done_pulses", 64'(n_done), 64'd1);
        chk("restart_eof_count", 64'(n_eof), 64'd1);
        chk("restart_last_ar", 64'(last_ar), 64'h100A_5600);
        chk("err_before_inject", 64'(err_snap), 64'd0);
        chk("err_sticky", 64'(resp_err), 64'd1);
        chk("restart_protocol", 64'(proto_err), 64'd0);

        // Asynchronous reset during the data phase of the first burst.
        reset_model();
        exp_base = BUF0;
        fs_n = 1'b1; sel_n = 1'b0;
        tick();
        fs_n = 1'b0;
        for (int i = 0; i < 500 && !(n_ar == 1 && cur_beat == 30); i++) tick();
        reached = (n_ar == 1 && cur_beat == 30);
        chk("reach_beat30", 64'(reached), 64'd1);
        #1;
        rst_n = 1'b0; rst_n_n = 1'b0;
        #1;
        chk("arst_arvalid_rready_valid", {61'd0, ARVALID, RREADY, out_valid}, 64'd0);
        chk("arst_state", 64'(state), 64'd0);
        chk("arst_busy_done_err", {61'd0, frame_busy, reader_done, resp_err}, 64'd0);
        chk("arst_araddr", 64'(ARADDR), 64'd0);
        reset_model();
        exp_base = BUF0;
        repeat (2) tick();
        rst_n_n = 1'b1;
        tick();
        fs_n = 1'b1; sel_n = 1'b0;
        tick();
        fs_n = 1'b0;
        for (int i = 0; i < 50 && n_ar == 0; i++) tick();
        chk("post_reset_first_ar", 64'(first_ar), 64'(BUF0));
        chk("post_reset_ar_count", 64'(n_ar), 64'd1);
        chk("post_reset_protocol", 64'(proto_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi4_frame_reader.md
Name: axi4_frame_reader

Overview:
- AXI4 read master; the downstream twin of the camera-side frame writer.
- Fetches one 320x240 RGB565 frame (153600 bytes) from DDR as 300 INCR bursts of 64 x 64-bit beats.
- Reads from whichever double buffer the writer is not filling, and streams the words to the HDMI-side read FIFO.
- Only one burst is outstanding at a time; a burst is issued only when the downstream FIFO guarantees room for all 64 beats.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width; fixed 8-byte beats.
- BURST_BEATS, 64, beats per burst (ARLEN = BURST_BEATS-1).
- FRAME_BYTES, 153600, bytes per frame; must be a multiple of BURST_BEATS*8.
- BUF0_BASE, 32'h1000_0000, base of buffer 0.
- BUF1_BASE, 32'h1008_0000, base of buffer 1.

Ports:
- clk_100Mhz  in  1  system/AXI clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse (HDMI vsync, already synchronised) requesting a new frame.
- rd_buf_select  in  1  buffer to read (0 -> BUF0_BASE, 1 -> BUF1_BASE); sampled on frame_start.
- space_ok  in  1  downstream FIFO has >= BURST_BEATS free words.
- ARADDR  out  32  burst address.
- ARVALID  out  1  address valid.
- ARREADY  in  1  address ready.
- ARLEN  out  8  constant 63.
- ARSIZE  out  3  constant 3'b011.
- ARBURST  out  2  constant INCR (2'b01).
- ARCACHE  out  4  constant 4'b0011.
- ARPROT  out  3  constant 3'b000.
- RDATA  in  64  read data.
- RRESP  in  2  read response.
- RLAST  in  1  last beat of burst.
- RVALID  in  1  data valid.
- RREADY  out  1  data ready.
- out_data  out  64  = RDATA (combinational).
- out_valid  out  1  RVALID && state==DATA.
- out_ready  in  1  downstream FIFO write ready.
- out_eof  out  1  qualifies the final beat of the frame.
- reader_done  out  1  one-cycle pulse after the last burst completes.
- frame_busy  out  1  high from frame accept until completion.
- resp_err  out  1  sticky: RRESP != OKAY, or RLAST mismatch.
- state  out  2  debug copy of the FSM state.

Behaviour:
- Reset values: all outputs 0; ARADDR=0; state=IDLE; counters 0; no frame pending.
- Reset asserted mid-burst drops ARVALID/RREADY immediately. The interconnect is reset on the same rst_n, so this is legal.
- State encoding: IDLE=0, ADDR=1, DATA=2, NEXT=3.
- IDLE:
  - On frame_start: base <= rd_buf_select ? BUF1_BASE : BUF0_BASE; offset <= 0; frame_busy <= 1.
  - If frame_busy && space_ok: ARADDR <= base+offset, go to ADDR.
- ADDR:
  - ARVALID=1 and held stable until ARVALID&&ARREADY; then ARVALID <= 0 next cycle, go to DATA.
  - ARVALID never drops without a handshake.
- DATA:
  - RREADY = out_ready (combinational); a beat transfers on RVALID&&RREADY.
  - beat_cnt (6 bits) increments per beat.
  - On the beat with beat_cnt==63, go to NEXT.
  - resp_err sets if RRESP!=0, if RLAST=1 on beat <63, or if RLAST=0 on beat 63. The burst still completes the count.
  - out_eof = out_valid && beat_cnt==63 && offset==FRAME_BYTES-512.
- NEXT (1 cycle):
  - If a restart is pending: apply it (new base, offset 0), go to IDLE.
  - Else if offset==FRAME_BYTES-512: reader_done <= 1 for one cycle; frame_busy <= 0; offset <= 0; go to IDLE.
  - Else: offset <= offset+512; go to IDLE.
- frame_start while frame_busy (ADDR/DATA/NEXT): an in-flight burst cannot be aborted. Latch restart_pending and the sampled buffer; apply at NEXT. No reader_done for the abandoned frame.
- frame_start arriving in IDLE while busy: restart immediately.
- Simultaneous frame_start and the NEXT completion cycle: the restart wins and reader_done is suppressed.
- space_ok low in IDLE: wait indefinitely with ARVALID=0.
- Offset arithmetic: 32-bit, unsigned, never wraps; the max address issued is base+153088.
- Latency: frame_start to ARVALID is 2 cycles when space_ok=1. Inter-burst gap is 3 cycles (NEXT, IDLE, ADDR).

Decomposition:
- Shared package axi_frame_pkg holds:
  - FSM localparams IDLE/ADDR/DATA/NEXT (shared with the writer);
  - AXI constants: BURST_LEN, SIZE_8B, BURST_INCR, CACHE_BUF, PROT_0;
  - FRAME_BYTES and BURST_BYTES=512.
- Single module; no sub-module is warranted. The HDMI FIFO stays outside the block.

Test Plan:
- Nominal frame: rd_buf_select=0, frame_start, space_ok=1, ARREADY/RVALID always 1 with RLAST on beat 63 -> 300 ARs at 0x1000_0000..0x1002_5600, 19200 out beats, out_eof on beat 19200, reader_done one pulse, resp_err=0.
- Backpressure: out_ready toggles 1-of-3 and ARREADY is delayed 5 cycles -> ARADDR/ARVALID stable while waiting, RREADY tracks out_ready, beat count still 19200, data order preserved.
- space_ok=0 for 100 cycles after frame_start -> ARVALID stays 0; first AR issues 2 cycles after space_ok rises.
- frame_start with rd_buf_select=1 during burst 10 beat 20 -> burst 10 completes all 64 beats; next AR is at 0x1008_0000; no reader_done for the first frame.
- RRESP=2'b10 on one beat, and RLAST early on beat 40 in a separate burst -> resp_err sets and stays 1; the FSM still consumes 64 beats per burst and finishes the frame.
- rst_n low during DATA beat 30 -> all outputs 0 and state=IDLE asynchronously; a new frame_start after release begins at offset 0.
